regfile_mp: RTL

Parametrised multi-port register file for the RV32I pipeline. It supersedes the single-write, two-read file with:
- configurable read/write port counts;
- same-cycle write-to-read forwarding across all write ports;
- a per-register pending (scoreboard) bit that flags destinations of loads still waiting on the one-cycle-delay SRAM;
- a sequential clear that walks the array after reset, so the array can map to flop or latch arrays without a wide reset fan-out.

It sits in ID (reads) and WB (writes), with the hazard unit consuming the pending flags.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_fwd_mux.sv | 36 +++
 rtl/regfile_mp.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type, default sizes and address-width helper for regfile_mp
package regfile_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_REG_DEPTH  = 32;
  typedef enum logic {INIT, RUN} state_e;
  function automatic int addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/regfile_fwd_mux.sv
// regfile_fwd_mux: one read port's priority forwarding over all write ports plus the pending mark
//   i_addr/i_arr_data/i_arr_pend : read address and the stored data/pending of that entry
//   i_we/i_wa/i_wd               : qualified write enables, addresses, data (flattened per port)
//   i_mark/i_mark_addr           : qualified same-cycle mark
//   o_data/o_pend                : forwarded read data and pending flag
module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int DW     = DEF_DATA_WIDTH,
  parameter int AW     = 5,
  parameter int NUM_WR = 2
) (
  input  logic [AW-1:0]        i_addr,
  input  logic [DW-1:0]        i_arr_data,
  input  logic                 i_arr_pend,
  input  logic [NUM_WR-1:0]    i_we,
  input  logic [NUM_WR*AW-1:0] i_wa,
  input  logic [NUM_WR*DW-1:0] i_wd,
  input  logic                 i_mark,
  input  logic [AW-1:0]        i_mark_addr,
  output logic [DW-1:0]        o_data,
  output logic                 o_pend
);
  // later ports overwrite earlier ones so the highest-indexed match wins; mark beats any write
  always_comb begin
    o_data = i_arr_data;
    o_pend = i_arr_pend;
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_we[j] && i_wa[j*AW+:AW] == i_addr) begin
        o_data = i_wd[j*DW+:DW];
        o_pend = 1'b0;
      end
    end
    if (i_mark && i_mark_addr == i_addr) o_pend = 1'b1;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write forwarding, load scoreboard and post-reset clear walk
//   clk_i/rst_ni             : clock, synchronous active-low reset
//   init_done_o              : high once every entry has been cleared
//   rd_addr_i/rd_data_o/rd_pend_o : NUM_RD combinational read ports with forwarding
//   we_i/wa_i/wd_i           : NUM_WR write ports, highest index wins on collision
//   mark_i/mark_addr_i       : flag a register as pending (load in flight)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_DEPTH  = DEF_REG_DEPTH,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1,
  localparam int AW        = addr_w(REG_DEPTH),
  localparam int DW        = DATA_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 init_done_o,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NUM_RD*DW-1:0] rd_data_o,
  output logic [NUM_RD-1:0]    rd_pend_o,
  input  logic [NUM_WR-1:0]    we_i,
  input  logic [NUM_WR*AW-1:0] wa_i,
  input  logic [NUM_WR*DW-1:0] wd_i,
  input  logic                 mark_i,
  input  logic [AW-1:0]        mark_addr_i
);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(REG_DEPTH - 1);
  state_e                r_state, w_state_nxt;
  logic [AW:0]           r_clr_cnt;
  logic [DW-1:0]         r_mem [REG_DEPTH];
  logic [REG_DEPTH-1:0]  r_pend;
  logic                  w_run, w_mark;
  logic [NUM_WR-1:0]     w_we;
  logic [NUM_RD*DW-1:0]  w_fwd_data;
  logic [NUM_RD-1:0]     w_fwd_pend;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= INIT;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= (r_state == INIT) ? r_clr_cnt + 1'b1 : r_clr_cnt;
    end
  end
  always_comb w_state_nxt = (r_state == INIT && r_clr_cnt == LAST_IDX) ? RUN : r_state;
  assign w_run       = r_state == RUN;
  assign init_done_o = w_run;
  // writes and marks only count in RUN and never touch a hardwired zero register
  always_comb begin
    w_we = '0;
    for (int j = 0; j < NUM_WR; j++)
      w_we[j] = w_run && we_i[j] && !(ZERO_REG != 0 && wa_i[j*AW+:AW] == '0);
  end
  assign w_mark = w_run && mark_i && !(ZERO_REG != 0 && mark_addr_i == '0);
  // the array has no reset; the INIT walk zeroes one entry per cycle instead
  always_ff @(posedge clk_i) begin
    if (r_state == INIT) r_mem[r_clr_cnt[AW-1:0]] <= '0;
    else
      for (int j = 0; j < NUM_WR; j++)
        if (w_we[j]) r_mem[wa_i[j*AW+:AW]] <= wd_i[j*DW+:DW];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_pend <= '0;
    else begin
      for (int j = 0; j < NUM_WR; j++)
        if (w_we[j]) r_pend[wa_i[j*AW+:AW]] <= 1'b0;
      if (w_mark) r_pend[mark_addr_i] <= 1'b1;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_zero;
    assign w_addr = rd_addr_i[k*AW+:AW];
    assign w_zero = ZERO_REG != 0 && w_addr == '0;
    regfile_fwd_mux #(.DW(DW), .AW(AW), .NUM_WR(NUM_WR)) u_fwd (
      .i_addr      (w_addr),
      .i_arr_data  (r_mem[w_addr]),
      .i_arr_pend  (r_pend[w_addr]),
      .i_we        (w_we),
      .i_wa        (wa_i),
      .i_wd        (wd_i),
      .i_mark      (w_mark),
      .i_mark_addr (mark_addr_i),
      .o_data      (w_fwd_data[k*DW+:DW]),
      .o_pend      (w_fwd_pend[k])
    );
    assign rd_data_o[k*DW+:DW] = (w_run && !w_zero) ? w_fwd_data[k*DW+:DW] : '0;
    assign rd_pend_o[k]        = w_run && !w_zero && w_fwd_pend[k];
  end
endmodule
